// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the data memory port: FSM states, access size
// codes and the byte-lane mask generator.
package mem_port_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_BAD
    } size_e;

    // Exactly one select must be set; anything else is an invalid request.
    function automatic size_e decode_size(input logic b_e, input logic h_e, input logic w_e);
        size_e sz;
        case ({b_e, h_e, w_e})
            3'b100:  sz = SZ_B;
            3'b010:  sz = SZ_H;
            3'b001:  sz = SZ_W;
            default: sz = SZ_BAD;
        endcase
        return sz;
    endfunction

    // Lanes touched across two consecutive words: [3:0] first word, [7:4] second.
    function automatic logic [2*WORD_BYTES-1:0] lane_mask(input size_e sz, input logic [1:0] off);
        logic [2*WORD_BYTES-1:0] base;
        case (sz)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/data_mem_port_if.sv
// Core-side request/response and memory-bus signals of the data memory port.
// master = the port itself, slave = the core and memory around it.
interface data_mem_port_if #(
    parameter int MEM_AW = 30
);
    logic              req_valid;
    logic [31:0]       addr;
    logic              wr;
    logic              b_e;
    logic              h_e;
    logic              w_e;
    logic [31:0]       w_in;
    logic [15:0]       h_in;
    logic [7:0]        b_in;
    logic [31:0]       mrdout;
    logic              rd_valid;
    logic              done;
    logic              err;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        input  req_valid, addr, wr, b_e, h_e, w_e, w_in, h_in, b_in, mem_rdata, mem_ack,
        output mrdout, rd_valid, done, err, busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, addr, wr, b_e, h_e, w_e, w_in, h_in, b_in, mem_rdata, mem_ack,
        input  mrdout, rd_valid, done, err, busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/byte_lane_align.sv
// Combinational lane steering: positions store data onto byte lanes of two
// consecutive words and extracts/masks load data back to a right-justified word.
module byte_lane_align
    import mem_port_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] w_i,
    input  logic [15:0] h_i,
    input  logic [7:0]  b_i,
    input  logic [31:0] lo_i,
    input  logic [23:0] hi_i,
    output logic [7:0]  mask_o,
    output logic [31:0] wdata_lo_o,
    output logic [31:0] wdata_hi_o,
    output logic [31:0] rdata_o
);

    logic [31:0] data;
    logic [63:0] wide;
    logic [31:0] extract;
    logic [31:0] size_mask;

    assign mask_o = lane_mask(size_i, off_i);

    always_comb begin
        // NOTE: each variable gets a default first so no path can infer a latch.
        data      = 32'h0;
        size_mask = 32'h0;
        case (size_i)
            SZ_B: begin
                data      = {24'h0, b_i};
                size_mask = 32'h0000_00FF;
            end
            SZ_H: begin
                data      = {16'h0, h_i};
                size_mask = 32'h0000_FFFF;
            end
            SZ_W: begin
                data      = w_i;
                size_mask = 32'hFFFF_FFFF;
            end
            default: ;
        endcase
    end

    assign wide       = {32'h0, data} << {off_i, 3'b000};
    assign wdata_lo_o = wide[31:0];
    assign wdata_hi_o = wide[63:32];

    // Only the low three bytes of the second word can ever reach the result.
    always_comb begin
        extract = lo_i;
        case (off_i)
            2'd1:    extract = {hi_i[7:0],  lo_i[31:8]};
            2'd2:    extract = {hi_i[15:0], lo_i[31:16]};
            2'd3:    extract = {hi_i[23:0], lo_i[31:24]};
            default: extract = lo_i;
        endcase
    end

    assign rdata_o = extract & size_mask;

endmodule

// File: rtl/data_mem_port.sv
// Memory-side access stage: turns a sized byte-address request into one or two
// word transactions with byte enables, with per-transaction ack timeout.
module data_mem_port
    import mem_port_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int MEM_AW  = 30
) (
    input logic             clk,
    input logic             rst_n,
    data_mem_port_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [31:0]       addr_q;
    logic              wr_q;
    size_e             size_q;
    logic [31:0]       w_q;
    logic [15:0]       h_q;
    logic [7:0]        b_q;
    logic [31:0]       lo_q;
    logic [CW-1:0]     cnt_q;
    logic              mem_req_q;
    logic              rd_valid_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       mrdout_q;

    size_e             size_in;
    logic              in_acc;
    logic              ack_fire;
    logic              tmo;
    logic              finish_ok;
    logic              split;
    logic [7:0]        mask;
    logic [31:0]       wdata_lo;
    logic [31:0]       wdata_hi;
    logic [31:0]       rd_lo;
    logic [23:0]       rd_hi;
    logic [31:0]       rd_data;
    logic [MEM_AW-1:0] word_addr;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;

    assign size_in   = decode_size(bus.b_e, bus.h_e, bus.w_e);
    assign in_acc    = (state_q == ACC0) || (state_q == ACC1);
    assign ack_fire  = in_acc && bus.mem_ack;
    assign tmo       = in_acc && !bus.mem_ack && (cnt_q == CW'(TIMEOUT - 1));
    assign split     = |mask[7:4];
    assign word_addr = addr_q[MEM_AW+1:2];

    // The first word comes straight off the bus on a single access, else from lo_q.
    assign rd_lo = (state_q == ACC0) ? bus.mem_rdata : lo_q;
    assign rd_hi = (state_q == ACC1) ? bus.mem_rdata[23:0] : 24'h0;

    byte_lane_align u_align (
        .size_i     (size_q),
        .off_i      (addr_q[1:0]),
        .w_i        (w_q),
        .h_i        (h_q),
        .b_i        (b_q),
        .lo_i       (rd_lo),
        .hi_i       (rd_hi),
        .mask_o     (mask),
        .wdata_lo_o (wdata_lo),
        .wdata_hi_o (wdata_hi),
        .rdata_o    (rd_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req_valid) state_d = (size_in == SZ_BAD) ? RESP : ACC0;
            ACC0: begin
                if (bus.mem_ack)  state_d = split ? ACC1 : RESP;
                else if (tmo)     state_d = RESP;
            end
            ACC1: if (bus.mem_ack || tmo) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign finish_ok = ack_fire && (state_d == RESP);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        case (state_q)
            ACC0: begin
                mem_we    = wr_q;
                mem_addr  = word_addr;
                mem_be    = mask[3:0];
                mem_wdata = wdata_lo;
            end
            ACC1: begin
                mem_we    = wr_q;
                mem_addr  = word_addr + MEM_AW'(1);
                mem_be    = mask[7:4];
                mem_wdata = wdata_hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            wr_q       <= 1'b0;
            size_q     <= SZ_BAD;
            w_q        <= 32'h0;
            h_q        <= 16'h0;
            b_q        <= 8'h0;
            lo_q       <= 32'h0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mrdout_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= (state_d == ACC0) || (state_d == ACC1);
            done_q     <= (state_d == RESP);
            err_q      <= tmo || ((state_q == IDLE) && bus.req_valid && (size_in == SZ_BAD));
            rd_valid_q <= finish_ok && !wr_q;
            if (finish_ok && !wr_q) mrdout_q <= rd_data;
            if ((state_q == IDLE) && bus.req_valid) begin
                addr_q <= bus.addr;
                wr_q   <= bus.wr;
                size_q <= size_in;
                w_q    <= bus.w_in;
                h_q    <= bus.h_in;
                b_q    <= bus.b_in;
            end
            if ((state_q == ACC0) && bus.mem_ack) lo_q <= bus.mem_rdata;
            // Counter restarts on every state change, so each transaction gets a full budget.
            if ((state_d != state_q) || !in_acc) cnt_q <= '0;
            else                                 cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_be    = mem_be;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mrdout    = mrdout_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
